dff_chain_ctrl: RTL and testbench

//  Controller that shares one WIDTH-bit DFF shift chain between two requesters.

---
 rtl/dff_chain_pkg.sv | 29 ++
 rtl/dff_chain_baud.sv | 41 ++++
 rtl/dff_chain_ctrl.sv | 107 ++++++++++
 tb/tb_dff_chain_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dff_chain_pkg.sv
// ============================================================================
// Module  : dff_chain_pkg
// Brief   : Shared types and constants for the shared DFF shift-chain controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dff_chain_pkg;

   localparam int   DEF_WIDTH = 8;
   localparam int   DEF_DIV_W = 16;
   localparam logic IDLE_MARK = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Round-robin pick: on contention the requester that did not win last time goes next.
   function automatic logic rr_pick(input logic [1:0] req, input logic last_owner);
      if (req == 2'b11) return ~last_owner;
      return req[1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/dff_chain_baud.sv
// ============================================================================
// Module  : dff_chain_baud
// Brief   : Bit-period counter; tick marks the last cycle of each bit period.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_chain_baud
   import dff_chain_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             ck,
   input  logic             clr,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [DIV_W-1:0] i_divisor,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_div_q;
   logic [DIV_W-1:0] r_cnt;

   // Counter never exceeds r_div_q, so an all-ones divisor cannot wrap.
   always_ff @(posedge ck or negedge clr) begin
      if (!clr) begin
         r_div_q <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_div_q <= i_divisor;
         r_cnt   <= '0;
      end else if (i_en) begin
         r_cnt <= o_tick ? '0 : r_cnt + DIV_W'(1);
      end
   end

   assign o_tick = i_en && (r_cnt == r_div_q);

endmodule

`default_nettype wire

// File: rtl/dff_chain_ctrl.sv
// ============================================================================
// Module  : dff_chain_ctrl
// Brief   : Round-robin shares one shift chain between two requesters, LSB-first out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_chain_ctrl
   import dff_chain_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             ck,
   input  logic             clr,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] din0,
   input  logic [WIDTH-1:0] din1,
   input  logic [DIV_W-1:0] divisor,
   output logic [1:0]       gnt,
   output logic             owner,
   output logic             busy,
   output logic             sout,
   output logic             done
);

   localparam int               CNT_W      = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic             r_winner;
   logic [WIDTH-1:0] r_chain;
   logic [CNT_W-1:0] r_bitcnt;
   logic             w_pick;
   logic             w_tick;
   logic [WIDTH-1:0] w_word;

   assign w_pick = rr_pick(req, owner);
   assign w_word = r_winner ? din1 : din0;

   dff_chain_baud #(
      .DIV_W (DIV_W)
   ) u_baud (
      .ck        (ck),
      .clr       (clr),
      .i_load    (r_state == LOAD),
      .i_en      (r_state == SHIFT),
      .i_divisor (divisor),
      .o_tick    (w_tick)
   );

   always_ff @(posedge ck or negedge clr) begin
      if (!clr) begin
         r_state  <= IDLE;
         r_winner <= 1'b1;
         r_chain  <= '0;
         r_bitcnt <= '0;
         gnt      <= 2'b00;
         owner    <= 1'b1;
         busy     <= 1'b0;
         sout     <= IDLE_MARK;
         done     <= 1'b0;
      end else begin
         gnt  <= 2'b00;
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req != 2'b00) begin
                  r_winner <= w_pick;
                  owner    <= w_pick;
                  gnt      <= {w_pick, ~w_pick};
                  busy     <= 1'b1;
                  r_state  <= LOAD;
               end
            end
            LOAD: begin
               r_chain  <= w_word;
               sout     <= w_word[0];
               r_bitcnt <= '0;
               r_state  <= SHIFT;
            end
            SHIFT: begin
               if (w_tick) begin
                  r_chain  <= r_chain >> 1;
                  r_bitcnt <= r_bitcnt + CNT_W'(1);
                  // sout is registered, so it takes the next bit ahead of the shift.
                  if (r_bitcnt == c_last_bit) begin
                     sout    <= IDLE_MARK;
                     done    <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     sout <= r_chain[1];
                  end
               end
            end
            DONE: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dff_chain_ctrl.sv
// ============================================================================
// Module  : tb_dff_chain_ctrl
// Brief   : Scoreboard bench for dff_chain_ctrl with a word-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dff_chain_ctrl;

   localparam int WIDTH = 8;
   localparam int DIV_W = 16;

   logic             ck;
   logic             clr;
   logic [1:0]       req;
   logic [WIDTH-1:0] din0;
   logic [WIDTH-1:0] din1;
   logic [DIV_W-1:0] divisor;
   logic [1:0]       gnt;
   logic             owner;
   logic             busy;
   logic             sout;
   logic             done;

   typedef struct {
      logic [1:0]       gnt;
      logic             owner;
      logic [WIDTH-1:0] word;
      int               period;
      bit               b2b;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   aborting = 0;
   logic m_owner  = 1'b1;

   dff_chain_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
      .ck      (ck),
      .clr     (clr),
      .req     (req),
      .din0    (din0),
      .din1    (din1),
      .divisor (divisor),
      .gnt     (gnt),
      .owner   (owner),
      .busy    (busy),
      .sout    (sout),
      .done    (done)
   );

   initial begin
      ck = 1'b0;
      forever #5 ck = ~ck;
   end

   always @(posedge ck) cyc <= cyc + 1;

   function automatic void chk(string nm, int act, int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
      end
   endfunction

   // Monitor: every grant pulse pops one expected word and follows it to its done pulse.
   initial begin : monitor
      exp_t e;
      int   done_cyc;
      done_cyc = -100;
      forever begin
         @(negedge ck);
         if (aborting) begin
         end else if (gnt != 2'b00) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_gnt", int'(gnt), 0);
            end else begin
               e = exp_q.pop_front();
               chk("gnt", int'(gnt), int'(e.gnt));
               chk("owner", int'(owner), int'(e.owner));
               chk("load_busy_sout", int'({busy, sout}), 3);
               if (e.b2b) chk("grant_gap", cyc - done_cyc, 2);
               for (int i = 0; i < WIDTH * e.period; i++) begin
                  @(negedge ck);
                  if (aborting) break;
                  chk("sout_bit", int'(sout), int'(e.word[i / e.period]));
                  chk("shift_ctl", int'({busy, gnt, done}), 8);
               end
               if (!aborting) begin
                  @(negedge ck);
                  if (!aborting) begin
                     chk("done_pulse", int'({done, sout, busy}), 7);
                     done_cyc = cyc;
                     @(negedge ck);
                     if (!aborting) chk("post_done", int'({done, busy, sout}), 1);
                  end
               end
            end
         end else begin
            if (done || busy || !sout) chk("idle_outputs", int'({done, busy, sout}), 1);
         end
      end
   end

   task automatic wait_gnt();
      bit seen;
      seen = 0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge ck);
         if (gnt != 2'b00) seen = 1;
      end
      if (!seen) chk("gnt_timeout", 0, 1);
   endtask

   task automatic wait_done(input int period);
      bit seen;
      seen = 0;
      for (int k = 0; k < WIDTH * period + 8 && !seen; k++) begin
         @(negedge ck);
         if (done) seen = 1;
      end
      if (!seen) chk("done_timeout", 0, 1);
   endtask

   // Reference model: winner from the round-robin rule; word and period frozen at grant.
   task automatic push_exp(input logic [1:0] r, input logic [DIV_W-1:0] dv, input bit b2b);
      exp_t e;
      logic w;
      if (r == 2'b11) w = ~m_owner;
      else            w = (r == 2'b10);
      e.gnt    = w ? 2'b10 : 2'b01;
      e.owner  = w;
      e.word   = w ? din1 : din0;
      e.period = int'(dv) + 1;
      e.b2b    = b2b;
      exp_q.push_back(e);
      m_owner  = w;
   endtask

   task automatic issue(input logic [1:0] r, input logic [DIV_W-1:0] dv,
                        input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                        input bit b2b, input bit hold, input logic [DIV_W-1:0] newdv);
      req     = r;
      divisor = dv;
      din0    = d0;
      din1    = d1;
      push_exp(r, dv, b2b);
      wait_gnt();
      if (!hold) req = 2'b00;
      @(negedge ck);
      din0    = WIDTH'($urandom);
      din1    = WIDTH'($urandom);
      divisor = newdv;
      wait_done(int'(dv) + 1);
   endtask

   initial begin : stim
      bit b2b;
      clr     = 1'b0;
      req     = 2'b00;
      din0    = '0;
      din1    = '0;
      divisor = '0;
      repeat (3) @(negedge ck);
      chk("reset_state", int'({gnt, owner, busy, sout, done}), 6'b001010);
      clr = 1'b1;
      @(negedge ck);

      issue(2'b01, 16'd0, 8'hA5, 8'h3C, 0, 0, 16'd0);
      issue(2'b10, 16'd3, 8'h77, 8'h01, 1, 0, 16'd3);
      for (int n = 0; n < 4; n++)
         issue(2'b11, 16'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 1, 1, 16'd5);

      // Abort during bit 3 of 8'hFF (period 3: SHIFT cycles 10..12).
      req = 2'b01; divisor = 16'd2; din0 = 8'hFF;
      push_exp(2'b01, 16'd2, 1);
      wait_gnt();
      req = 2'b00;
      repeat (10) @(negedge ck);
      aborting = 1;
      clr      = 1'b0;
      #1;
      chk("abort_outputs", int'({gnt, owner, busy, sout, done}), 6'b001010);
      repeat (3) @(negedge ck);
      clr = 1'b1;
      repeat (2) @(negedge ck);
      exp_q.delete();
      m_owner  = 1'b1;
      aborting = 0;
      repeat (4) @(negedge ck);
      chk("no_done_after_abort", int'({done, busy}), 0);

      issue(2'b01, 16'd2, 8'hFF, 8'h00, 0, 0, 16'd0);
      issue(2'b10, 16'd0, 8'h5A, 8'hC3, 1, 0, 16'd7);
      issue(2'b11, 16'd255, 8'h96, 8'h69, 1, 0, 16'd0);

      b2b = 1;
      for (int n = 0; n < 16; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            req = 2'b00;
            repeat ($urandom_range(1, 4)) @(negedge ck);
            b2b = 0;
         end
         issue(2'($urandom_range(1, 3)), 16'($urandom_range(0, 4)), 8'($urandom), 8'($urandom),
               b2b, bit'($urandom_range(0, 1)), 16'($urandom_range(0, 6)));
         b2b = 1;
      end

      req = 2'b00;
      repeat (5) @(negedge ck);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
